// File: rtl/i2s_pkg.sv
// Shared types and frame-geometry helpers for the I2S transmitter.
// WS leads the MSB by one slot (Philips format), hence the lead offset.
package i2s_pkg;

  typedef enum logic {IDLE, RUN} state_t;

  localparam int ws_lead_c = 1;

  function automatic int frame_len(input int width);
    return 2 * width;
  endfunction

  function automatic int ws_first(input int width);
    return width - ws_lead_c;
  endfunction

  function automatic int ws_last(input int width);
    return 2 * width - 1 - ws_lead_c;
  endfunction

endpackage

// File: rtl/i2s_sclk_gen.sv
// Bit-clock divider: SCLK low for div_p cycles, then high for div_p cycles.
// slot_start marks the last cycle of a slot, so its closing edge opens the next slot.
module i2s_sclk_gen #(
  parameter int div_p = 4
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic run,
  output logic sclk,
  output logic slot_start
);

  localparam int cw_c = (div_p > 1) ? $clog2(div_p) : 1;
  localparam logic [cw_c-1:0] last_c = cw_c'(div_p - 1);

  logic [cw_c-1:0] cnt;
  logic            half;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt  <= '0;
      half <= 1'b0;
    end else if (!run) begin
      cnt  <= '0;
      half <= 1'b0;
    end else if (cnt == last_c) begin
      cnt  <= '0;
      half <= ~half;
    end else begin
      cnt <= cnt + cw_c'(1);
    end
  end

  assign sclk       = half;
  assign slot_start = run && half && (cnt == last_c);

endmodule

// File: rtl/i2s_tx.sv
// Philips I2S transmitter: one-deep holding register feeding a frame shift register.
// Frames run back-to-back while enabled; an empty holder at a boundary sends zeros.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int width_p = 16,
  parameter int div_p   = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_ni,
  input  logic                 en_i,
  input  logic [2*width_p-1:0] data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic                 sclk_o,
  output logic                 ws_o,
  output logic                 sd_o,
  output logic                 underrun_o,
  output logic                 busy_o
);

  localparam int fl_c = frame_len(width_p);
  localparam int sw_c = $clog2(fl_c);
  localparam logic [sw_c-1:0] last_slot_c = sw_c'(fl_c - 1);
  localparam logic [sw_c-1:0] ws_first_c  = sw_c'(ws_first(width_p));
  localparam logic [sw_c-1:0] ws_last_c   = sw_c'(ws_last(width_p));

  state_t            state;
  logic [sw_c-1:0]   slot;
  logic [sw_c-1:0]   next_slot;
  logic [fl_c-1:0]   shreg;
  logic [fl_c-1:0]   hold;
  logic [fl_c-1:0]   next_word;
  logic              hold_full;
  logic              run;
  logic              slot_start;
  logic              load;
  logic              boundary;
  logic              start;
  logic              take;

  function automatic logic in_ws(input logic [sw_c-1:0] b);
    return (b >= ws_first_c) && (b <= ws_last_c);
  endfunction

  i2s_sclk_gen #(.div_p(div_p)) u_sclk_gen (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .run        (run),
    .sclk       (sclk_o),
    .slot_start (slot_start)
  );

  assign run       = (state == RUN);
  assign busy_o    = run;
  assign load      = valid_i && ready_o;
  assign boundary  = run && slot_start && (slot == last_slot_c);
  assign start     = en_i && (boundary || ((state == IDLE) && hold_full));
  assign take      = start && hold_full;
  assign next_word = hold_full ? hold : '0;
  assign next_slot = slot + sw_c'(1);

  // en_i only matters at frame boundaries, so a mid-frame drop never truncates.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state      <= IDLE;
      slot       <= '0;
      shreg      <= '0;
      hold       <= '0;
      hold_full  <= 1'b0;
      ready_o    <= 1'b0;
      sd_o       <= 1'b0;
      ws_o       <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      underrun_o <= 1'b0;

      if (load) begin
        hold      <= data_i;
        hold_full <= 1'b1;
        ready_o   <= 1'b0;
      end else if (take) begin
        hold_full <= 1'b0;
        ready_o   <= 1'b1;
      end else begin
        ready_o <= !hold_full;
      end

      if (start) begin
        state      <= RUN;
        slot       <= '0;
        shreg      <= next_word;
        sd_o       <= next_word[fl_c-1];
        ws_o       <= in_ws('0);
        underrun_o <= !hold_full;
      end else if (boundary) begin
        state <= IDLE;
        slot  <= '0;
        sd_o  <= 1'b0;
        ws_o  <= 1'b0;
      end else if (run && slot_start) begin
        slot  <= next_slot;
        shreg <= shreg << 1;
        sd_o  <= shreg[fl_c-2];
        ws_o  <= in_ws(next_slot);
      end
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Directed-sequence bench for i2s_tx (width 16, divider 2) with random sample words.
// Expected line activity is computed from frame position: slot = k/4, phase = k%4.
module tb_i2s_tx;

  localparam int width_c = 16;
  localparam int div_c   = 2;
  localparam int slot_clks_c  = 2 * div_c;
  localparam int frame_clks_c = 2 * width_c * slot_clks_c;

  logic        clk_i = 1'b0;
  logic        reset_ni;
  logic        en_i;
  logic [31:0] data_i;
  logic        valid_i;
  logic        ready_o;
  logic        sclk_o;
  logic        ws_o;
  logic        sd_o;
  logic        underrun_o;
  logic        busy_o;

  int n_asserts = 0;
  int n_fail    = 0;

  i2s_tx #(.width_p(width_c), .div_p(div_c)) dut (
    .clk_i      (clk_i),
    .reset_ni   (reset_ni),
    .en_i       (en_i),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .sclk_o     (sclk_o),
    .ws_o       (ws_o),
    .sd_o       (sd_o),
    .underrun_o (underrun_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s at %0t: observed %h expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag, input logic exp_ready);
    check({tag, " sd"}, {31'd0, sd_o}, 32'd0);
    check({tag, " ws"}, {31'd0, ws_o}, 32'd0);
    check({tag, " sclk"}, {31'd0, sclk_o}, 32'd0);
    check({tag, " busy"}, {31'd0, busy_o}, 32'd0);
    check({tag, " underrun"}, {31'd0, underrun_o}, 32'd0);
    check({tag, " ready"}, {31'd0, ready_o}, {31'd0, exp_ready});
  endtask

  // Waits (bounded) for ready, then performs one handshake; returns just after it.
  task automatic push(input logic [31:0] word);
    data_i  = word;
    valid_i = 1'b1;
    for (int i = 0; i < 300 && ready_o !== 1'b1; i++) tick();
    check("push ready", {31'd0, ready_o}, 32'd1);
    tick();
    valid_i = 1'b0;
    check("ready after load", {31'd0, ready_o}, 32'd0);
  endtask

  // Called right after a frame-start edge; checks all 128 clocks of the frame.
  task automatic check_frame(input logic [31:0] word, input logic exp_under,
                             input int push_k, input logic [31:0] push_word,
                             input int drop_k);
    for (int k = 0; k < frame_clks_c; k++) begin
      int  b;
      logic exp_ws;
      b = k / slot_clks_c;
      exp_ws = (b >= width_c - 1) && (b <= 2 * width_c - 2);
      check("sd", {31'd0, sd_o}, {31'd0, word[31-b]});
      check("ws", {31'd0, ws_o}, {31'd0, exp_ws});
      check("sclk", {31'd0, sclk_o}, {31'd0, (k % slot_clks_c) >= div_c});
      check("busy", {31'd0, busy_o}, 32'd1);
      check("underrun", {31'd0, underrun_o}, {31'd0, (k == 0) ? exp_under : 1'b0});
      if (k == 0) check("ready at frame start", {31'd0, ready_o}, 32'd1);
      if (k == push_k + 1) begin
        valid_i = 1'b0;
        check("ready after mid-frame load", {31'd0, ready_o}, 32'd0);
      end
      if (k == push_k) begin
        data_i  = push_word;
        valid_i = 1'b1;
      end
      if (k == drop_k) en_i = 1'b0;
      tick();
    end
  endtask

  initial begin
    logic [31:0] w1, w2, w3, w4, w5, w6, w7;
    w1 = $urandom; w2 = $urandom; w3 = $urandom; w4 = $urandom;
    w5 = $urandom; w6 = $urandom; w7 = $urandom;

    reset_ni = 1'b0;
    en_i     = 1'b0;
    valid_i  = 1'b0;
    data_i   = '0;

    for (int i = 0; i < 3; i++) begin
      tick();
      check_quiet("in reset", 1'b0);
    end
    reset_ni = 1'b1;
    tick();
    check_quiet("after reset", 1'b1);

    $display("[TB] single frame");
    en_i = 1'b1;
    push(32'hA5F0_0F5A);
    tick();
    check_frame(32'hA5F0_0F5A, 1'b0, -10, '0, 100);
    check_quiet("idle after single", 1'b1);

    $display("[TB] back-to-back then underrun");
    en_i = 1'b1;
    push(w1);
    tick();
    check_frame(w1, 1'b0, 10, w2, -10);
    check_frame(w2, 1'b0, -10, '0, -10);
    check_frame(32'h0, 1'b1, -10, '0, 60);
    check_quiet("idle after underrun", 1'b1);

    $display("[TB] enable drop with queued word");
    en_i = 1'b1;
    push(w3);
    tick();
    check_frame(w3, 1'b0, 10, w4, 20);
    for (int i = 0; i < 12; i++) begin
      check_quiet("idle holding", 1'b0);
      tick();
    end
    en_i = 1'b1;
    tick();
    check_frame(w4, 1'b0, -10, '0, 100);
    check_quiet("idle after queued", 1'b1);

    $display("[TB] reset mid-frame");
    en_i = 1'b1;
    push(w5);
    tick();
    for (int k = 0; k < 40; k++) begin
      if (k == 11) valid_i = 1'b0;
      if (k == 10) begin
        data_i  = w6;
        valid_i = 1'b1;
      end
      tick();
    end
    check("busy before abort", {31'd0, busy_o}, 32'd1);
    reset_ni = 1'b0;
    #1;
    check_quiet("async abort", 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_quiet("held in reset", 1'b0);
    end
    reset_ni = 1'b1;
    tick();
    check_quiet("released", 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick();
      check_quiet("no frame without push", 1'b1);
    end
    push(w7);
    tick();
    check_frame(w7, 1'b0, -10, '0, 100);
    check_quiet("final idle", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
